// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the CTS-gated UART transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CTS = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STOP     = 3'd4,
        ST_DONE     = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16-bit bit-period counter. Emits a one-cycle tick on count
// CLKS_PER_BIT-1 and wraps to 0; clear (or !enable) holds the count at 0.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] TERMINAL = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    assign tick = enable && !clear && (count == TERMINAL);

    // Count cycles within the current bit; restart on each tick.
    always_ff @(posedge clock) begin
        if (reset || clear || !enable) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_cts_tcvr.sv
// uart_cts_tcvr: 8N1 UART transmitter with a level request/pulse-done
// handshake and a completed-byte counter.
// Build option UART_CTS_FLOW_EN: when defined, a frame waits in WAIT_CTS
// until the synchronized clear-to-send is high; when undefined, WAIT_CTS
// lasts one cycle and uart_cts is ignored.
module uart_cts_tcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] uart_data,
    input  logic                      send_uart_data,
    input  logic                      uart_cts,
    output logic                      uart_tx,
    output logic                      uart_data_sent,
    output logic                      busy,
    output logic [15:0]               tx_count
);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [2:0]                bit_idx;
    logic                      cts_meta;
    logic                      cts_sync;
    logic                      cts_ok;
    logic                      tick;
    logic                      bit_active;
    logic                      tx_nxt;
    logic                      tx_q;
    logic                      sent_q;
    logic [15:0]               count_q;

    // Two-flop synchronizer for the asynchronous clear-to-send.
    always_ff @(posedge clock) begin
        if (reset) begin
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
        end else begin
            cts_meta <= uart_cts;
            cts_sync <= cts_meta;
        end
    end

`ifdef UART_CTS_FLOW_EN
    assign cts_ok = cts_sync;
`else
    // Synchronizer is kept so reset behaviour matches the gated build.
    logic unused_cts_sync;
    assign unused_cts_sync = cts_sync;
    assign cts_ok          = 1'b1;
`endif

    // The bit counter only runs while a line bit is being driven.
    assign bit_active = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (!bit_active),
        .enable(bit_active),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next line level from the current state.
    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            ST_IDLE:     if (send_uart_data) state_nxt = ST_WAIT_CTS;
            ST_WAIT_CTS: if (cts_ok) state_nxt = ST_START;
            ST_START: begin
                tx_nxt = 1'b0;
                if (tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_nxt = shift_q[0];
                if (tick && (bit_idx == 3'(UART_DATA_BITS - 1))) state_nxt = ST_STOP;
            end
            ST_STOP:     if (tick) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Latch the byte at acceptance and shift it out LSB first.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            bit_idx <= '0;
        end else if ((state == ST_IDLE) && send_uart_data) begin
            shift_q <= uart_data;
            bit_idx <= '0;
        end else if ((state == ST_DATA) && tick) begin
            shift_q <= shift_q >> 1;
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Registered line, done pulse and byte counter (counter written every cycle).
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_q    <= 1'b1;
            sent_q  <= 1'b0;
            count_q <= '0;
        end else begin
            tx_q    <= tx_nxt;
            sent_q  <= (state == ST_DONE);
            count_q <= count_q + {15'd0, (state == ST_DONE)};
        end
    end

    assign uart_tx        = tx_q;
    assign uart_data_sent = sent_q;
    assign busy           = (state != ST_IDLE);
    assign tx_count       = count_q;

endmodule

// File: tb/tb_uart_cts_tcvr.sv
// tb_uart_cts_tcvr: self-checking bench for uart_cts_tcvr at CLKS_PER_BIT=4.
// The reference model derives each frame's expected line waveform, done
// pulse and busy level from the frame layout (start, 8 data LSB first, stop).
module tb_uart_cts_tcvr;

    localparam int CPB = 4;
`ifdef UART_CTS_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  uart_data = 8'h00;
    logic        send_uart_data = 1'b0;
    logic        uart_cts = 1'b1;
    logic        uart_tx;
    logic        uart_data_sent;
    logic        busy;
    logic [15:0] tx_count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = 16'd0;

    uart_cts_tcvr #(.CLKS_PER_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_data     (uart_data),
        .send_uart_data(send_uart_data),
        .uart_cts      (uart_cts),
        .uart_tx       (uart_tx),
        .uart_data_sent(uart_data_sent),
        .busy          (busy),
        .tx_count      (tx_count)
    );

    always #5 clock = ~clock;

    // One frame: request at a negedge, acceptance on the following posedge
    // (n=0). raise_at/drop_at (-1 = never) toggle uart_cts after sample n.
    task automatic run_frame(input logic [7:0] d, input int raise_at, input int drop_at);
        int         s;
        int         last;
        logic [9:0] bits;
        logic       exp_tx;
        logic       exp_sent;
        logic       exp_busy;
        bits = {1'b1, d, 1'b0};
        s = 2;
        if (FLOW && (raise_at >= 0)) s = raise_at + 4;
        last = s + 10 * CPB;
        @(negedge clock);
        uart_data      = d;
        send_uart_data = 1'b1;
        for (int n = 0; n <= last; n++) begin
            @(negedge clock);
            exp_tx   = ((n < s) || (n >= last)) ? 1'b1 : bits[(n - s) / CPB];
            exp_sent = (n == last);
            exp_busy = (n < last);
            n_vec++;
            if ({uart_tx, uart_data_sent, busy} !== {exp_tx, exp_sent, exp_busy}) begin
                n_bad++;
                $display("FAIL frame_%02h n=%0d tx/sent/busy got %b%b%b want %b%b%b",
                         d, n, uart_tx, uart_data_sent, busy, exp_tx, exp_sent, exp_busy);
            end
            if (n == 0) uart_data = 8'($urandom);
            if (n == raise_at) uart_cts = 1'b1;
            if (n == drop_at) uart_cts = 1'b0;
            if (exp_sent) send_uart_data = 1'b0;
        end
        exp_count = exp_count + 16'd1;
        n_vec++;
        if (tx_count !== exp_count) begin
            n_bad++;
            $display("FAIL count_after_%02h got %0d want %0d", d, tx_count, exp_count);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        send_uart_data = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_count = 16'd0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_vec++;
        if ({uart_tx, uart_data_sent, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_outputs tx/sent/busy got %b%b%b want 100", uart_tx, uart_data_sent, busy);
        end
        n_vec++;
        if (tx_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_count got %0d want 0", tx_count);
        end
        reset = 1'b0;
        exp_count = 16'd0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single();
        run_frame(8'hA5, -1, -1);
    endtask

    task automatic test_cts_gating();
        uart_cts = 1'b0;
        repeat (3) @(negedge clock);
        run_frame(8'h3C, 100, -1);
        uart_cts = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_cts_drop();
        run_frame(8'hFF, -1, 2 + 4 * CPB + 1);
        uart_cts = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [5] = '{8'h01, 8'h0A, 8'h14, 8'h1E, 8'h28};
        apply_reset();
        foreach (seq[i]) run_frame(seq[i], -1, -1);
        n_vec++;
        if (tx_count !== 16'd5) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want 5", tx_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clock);
        uart_data      = 8'hC3;
        send_uart_data = 1'b1;
        for (int n = 0; n <= 23; n++) @(negedge clock);
        reset          = 1'b1;
        send_uart_data = 1'b0;
        @(negedge clock);
        exp_count = 16'd0;
        n_vec++;
        if ({uart_tx, uart_data_sent, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL midreset_outputs tx/sent/busy got %b%b%b want 100", uart_tx, uart_data_sent, busy);
        end
        n_vec++;
        if (tx_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_count got %0d want 0", tx_count);
        end
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            n_vec++;
            if ({uart_tx, uart_data_sent} !== 2'b10) begin
                n_bad++;
                $display("FAIL midreset_idle n=%0d tx/sent got %b%b want 10", n, uart_tx, uart_data_sent);
            end
        end
        run_frame(8'h55, -1, -1);
    endtask

    task automatic test_count_wrap();
        @(negedge clock);
        force dut.count_q = 16'hFFFF;
        @(negedge clock);
        release dut.count_q;
        @(negedge clock);
        exp_count = 16'hFFFF;
        n_vec++;
        if (tx_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_preload got %h want ffff", tx_count);
        end
        run_frame(8'($urandom), -1, -1);
        n_vec++;
        if (tx_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_result got %h want 0000", tx_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_frame(8'($urandom), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cts_gating();
        test_cts_drop();
        test_back_to_back();
        test_reset_mid_frame();
        test_count_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
